hier_walk_ctrl: RTL

- Hardware traversal sequencer that walks a component hierarchy stored in an external node table and presents each node to a downstream visitor engine, in depth-first order.
- Each node record holds first-child, next-sibling and parent pointers.
- The block owns the node-table read port, sequences the walk without a stack (pointer chasing plus a depth counter), and throttles on visitor backpressure.

---
 rtl/hier_walk_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/hier_walk_ctrl.sv
// Stackless depth-first walker: chases child/sibling/parent pointers in a node table
// and streams ENTER (and, with HIER_WALK_LEAVE_EN defined, LEAVE) events to a visitor.
module hier_walk_ctrl #(
    parameter int unsigned AW         = 8,
    parameter int unsigned DEPTH_W    = 4,
    parameter int unsigned MAX_DEPTH  = 15,
    parameter int unsigned MAX_VISITS = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AW-1:0]      root,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_req,
    output logic [AW-1:0]      rd_addr,
    input  logic               rd_valid,
    input  logic [AW-1:0]      rd_child,
    input  logic [AW-1:0]      rd_sibling,
    input  logic [AW-1:0]      rd_parent,
    output logic               visit_valid,
    input  logic               visit_ready,
    output logic [AW-1:0]      visit_node,
    output logic [DEPTH_W-1:0] visit_depth,
    output logic               visit_leave
);

    localparam int unsigned   CNT_W = $clog2(MAX_VISITS + 1);
    localparam logic [AW-1:0] NIL   = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_ENTER, S_LEAVE, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t             state, state_d;
    logic [AW-1:0]      cur, cur_d, root_q, root_d;
    logic [AW-1:0]      child_q, child_d, sib_q, sib_d, par_q, par_d;
    logic [DEPTH_W-1:0] depth, depth_d;
    logic [CNT_W-1:0]   count, count_d;
    logic               asc, asc_d;
    logic               xfer;

    logic               busy_d, done_d, err_d, rd_req_d, visit_valid_d, visit_leave_d;
    logic [AW-1:0]      rd_addr_d, visit_node_d;
    logic [DEPTH_W-1:0] visit_depth_d;

    assign xfer = visit_valid & visit_ready;

    // Next-state, walk registers and registered-output decode
    always_comb begin
        state_d = state;
        cur_d   = cur;
        root_d  = root_q;
        child_d = child_q;
        sib_d   = sib_q;
        par_d   = par_q;
        depth_d = depth;
        count_d = count;
        asc_d   = asc;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cur_d   = root;
                    root_d  = root;
                    depth_d = '0;
                    count_d = '0;
                    asc_d   = 1'b0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (rd_valid) begin
                    child_d = rd_child;
                    sib_d   = rd_sibling;
                    par_d   = rd_parent;
                    state_d = asc ? S_LEAVE : S_ENTER;
                end
            end
            S_ENTER: begin
                if (count == CNT_W'(MAX_VISITS)) begin
                    state_d = S_ERR;
                end else if (xfer) begin
                    count_d = count + CNT_W'(1);
                    if (child_q == NIL) begin
                        state_d = S_LEAVE;
                    end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        cur_d   = child_q;
                        depth_d = depth + DEPTH_W'(1);
                        asc_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_LEAVE: begin
`ifdef HIER_WALK_LEAVE_EN
                if (xfer) state_d = S_NEXT;
`else
                state_d = S_NEXT;
`endif
            end
            S_NEXT: begin
                // The root's sibling pointer is never followed
                if (cur == root_q) begin
                    state_d = S_DONE;
                end else if (sib_q != NIL) begin
                    cur_d   = sib_q;
                    asc_d   = 1'b0;
                    state_d = S_FETCH;
                end else if (par_q == NIL) begin
                    state_d = S_ERR;
                end else begin
                    cur_d   = par_q;
                    depth_d = depth - DEPTH_W'(1);
                    asc_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition once a walk is under way
        if (abort && (state != S_IDLE)) state_d = S_IDLE;

        busy_d   = state_d inside {S_FETCH, S_WAIT, S_ENTER, S_LEAVE, S_NEXT};
        done_d   = (state_d == S_DONE);
        err_d    = err;
        if ((state == S_IDLE) && start) err_d = 1'b0;
        if (state_d == S_ERR)           err_d = 1'b1;
        rd_req_d  = (state_d == S_FETCH);
        rd_addr_d = rd_req_d ? cur_d : rd_addr;

        visit_valid_d = (state_d == S_ENTER) && (count_d != CNT_W'(MAX_VISITS));
        visit_leave_d = 1'b0;
`ifdef HIER_WALK_LEAVE_EN
        if (state_d == S_LEAVE) begin
            visit_valid_d = 1'b1;
            visit_leave_d = 1'b1;
        end
`endif
        visit_node_d  = visit_node;
        visit_depth_d = visit_depth;
        if ((state_d == S_ENTER) || (state_d == S_LEAVE)) begin
            visit_node_d  = cur_d;
            visit_depth_d = depth_d;
        end
    end

    // State, walk context and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur         <= '0;
            root_q      <= '0;
            child_q     <= '0;
            sib_q       <= '0;
            par_q       <= '0;
            depth       <= '0;
            count       <= '0;
            asc         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            visit_valid <= 1'b0;
            visit_node  <= '0;
            visit_depth <= '0;
            visit_leave <= 1'b0;
        end else begin
            state       <= state_d;
            cur         <= cur_d;
            root_q      <= root_d;
            child_q     <= child_d;
            sib_q       <= sib_d;
            par_q       <= par_d;
            depth       <= depth_d;
            count       <= count_d;
            asc         <= asc_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            rd_req      <= rd_req_d;
            rd_addr     <= rd_addr_d;
            visit_valid <= visit_valid_d;
            visit_node  <= visit_node_d;
            visit_depth <= visit_depth_d;
            visit_leave <= visit_leave_d;
        end
    end

endmodule
